// File: rtl/mole_responder.sv
// mole_responder: whack-a-mole style reaction unit.
// Accepts a target light index, lights it, waits for a debounced button
// press or window expiry, then holds the result until it is consumed.
// Optional feature macro: MOLE_REACTION_TIME_EN (builds the react_time capture).
module mole_responder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WINDOW_CYCLES   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  target,
    input  logic [3:0]  buttons,
    output logic [3:0]  lights,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_hit,
    output logic        res_timeout,
    output logic [15:0] react_time
);

    localparam int              DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]     TIMER_LAST = 16'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             sync_p0;
    logic [3:0]             sync_p1;
    logic [3:0]             deb_q;
    logic [3:0]             deb_prev_q;
    logic [3:0][DB_W-1:0]   db_cnt_q;
    logic [1:0]             target_q;
    logic [15:0]            timer_q;
    logic [3:0]             press;
    logic [3:0]             target_oh;
    logic                   hs;
    logic                   hit;
    logic                   wrong;
    logic                   expire;
    logic                   decide;

    // Two-flop synchronizer on the raw asynchronous buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= buttons;
            sync_p1 <= sync_p0;
        end
    end

    // Debouncer: a bit flips only after DEBOUNCE_CYCLES consecutive samples
    // disagreeing with its current level; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            db_cnt_q   <= '0;
        end else begin
            deb_prev_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= sync_p1[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A press is a rising edge of the debounced level; a button already held
    // when the round starts produces no edge until it is released and pressed again.
    assign press     = deb_q & ~deb_prev_q;
    assign target_oh = 4'b0001 << target_q;
    assign decide    = hit | wrong | expire;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and outputs; a wrong press outranks a hit, any press outranks timeout.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        lights    = 4'b0000;
        res_valid = 1'b0;
        hs        = 1'b0;
        hit       = 1'b0;
        wrong     = 1'b0;
        expire    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    hs      = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                lights = target_oh;
                if ((press & ~target_oh) != 4'b0000) begin
                    wrong   = 1'b1;
                    state_d = REPORT;
                end else if ((press & target_oh) != 4'b0000) begin
                    hit     = 1'b1;
                    state_d = REPORT;
                end else if (timer_q == TIMER_LAST) begin
                    expire  = 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Round registers: target latch, window timer and result flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q    <= 2'd0;
            timer_q     <= 16'd0;
            res_hit     <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            if (hs) begin
                target_q <= target;
                timer_q  <= 16'd0;
            end else if (state_q == ARMED) begin
                timer_q <= timer_q + 16'd1;
            end
            if (decide) begin
                res_hit     <= hit;
                res_timeout <= expire;
            end
        end
    end

`ifdef MOLE_REACTION_TIME_EN
    logic [15:0] react_q;

    // Capture the timer at the deciding event; on expiry it already holds WINDOW_CYCLES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            react_q <= 16'd0;
        end else if (decide) begin
            react_q <= timer_q;
        end
    end

    assign react_time = react_q;
`else
    assign react_time = 16'd0;
`endif

endmodule
